xor_mux_share_arbiter: RTL and testbench

- Shares one W-bit XOR-via-mux compute unit among N_REQ requesters.
- Round-robin arbitration, a valid/ready request handshake per requester, and a single shared response channel tagged with the requester id.
- Sits between the per-lane drivers of the gates exercises and the shared vector XOR datapath.
- One operation is in flight at a time.

---
 rtl/xor_mux_share_arbiter_pkg.sv | 44 ++++
 rtl/xor_mux_share_arbiter_xor.sv | 17 +
 rtl/xor_mux_share_arbiter.sv | 155 +++++++++++++++
 tb/tb_xor_mux_share_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_mux_share_arbiter_pkg.sv
// Shared types and helpers for xor_mux_share_arbiter.
//   state_t  : arbiter FSM encoding (IDLE, EXEC, RESP)
//   pick_t   : result of a round-robin scan (found flag + winner index)
//   rr_pick  : round-robin winner search over up to MAX_REQ requesters
package xor_mux_share_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int MAX_REQ  = 16;
  localparam int MAX_ID_W = 4;

  typedef struct packed {
    logic                found;
    logic [MAX_ID_W-1:0] idx;
  } pick_t;

  // First set bit of valid, scanning ptr, ptr+1, ... and wrapping n-1 -> 0.
  // ptr < n is assumed, so ptr + k never needs more than one subtraction
  // to wrap, which keeps the search free of a modulo operator.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]  valid,
                                    input logic [MAX_ID_W-1:0] ptr,
                                    input int                  n);
    pick_t res;
    int    j;
    res.found = 1'b0;
    res.idx   = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < n) begin
        j = int'(ptr) + k;
        if (j >= n) j = j - n;
        if (!res.found && valid[MAX_ID_W'(j)]) begin
          res.found = 1'b1;
          res.idx   = MAX_ID_W'(j);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/xor_mux_share_arbiter_xor.sv
// xor_vec_using_mux: purely combinational W-bit XOR built from 2:1 muxes.
// Each output bit selects ~a when b is set and a otherwise.
//   a, b : operands (W bits)
//   o    : a ^ b   (W bits)
module xor_vec_using_mux #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] o
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign o[i] = b[i] ? ~a[i] : a[i];
  end

endmodule

// File: rtl/xor_mux_share_arbiter.sv
// xor_mux_share_arbiter: shares one XOR-via-mux unit among N_REQ requesters.
// Round-robin grant in IDLE, one EXEC cycle to register the result, then a
// tagged response held in RESP until the consumer accepts it.
//
// Handshake rule (both request and response channels): a transfer happens on
// a rising clk edge where valid and ready are both high; the sender holds
// valid and its data stable until that edge; ready may depend
// combinationally on valid.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   req_valid/ready  per-requester handshake (ready is one-hot or zero)
//   req_a, req_b     flattened operands, requester i at [i*W +: W]
//   rsp_valid/ready  shared response handshake
//   rsp_data, rsp_id result a^b and issuing requester index
//   busy             FSM not in IDLE
//   op_count         completed responses, wraps modulo 2^CNT_W
//   dbg_state        current FSM state
//   dbg_rr_ptr       current round-robin start pointer
module xor_mux_share_arbiter
  import xor_mux_share_arbiter_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int W     = 8,
  parameter  int CNT_W = 16,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [W-1:0]       rsp_data,
  output logic [ID_W-1:0]    rsp_id,
  output logic               busy,
  output logic [CNT_W-1:0]   op_count,
  output state_t             dbg_state,
  output logic [ID_W-1:0]    dbg_rr_ptr
);

  state_t             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [W-1:0]       rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [CNT_W-1:0]   op_count_q, op_count_d;

  logic [MAX_REQ-1:0] valid_ext;
  pick_t              pick;
  logic [ID_W-1:0]    win_idx;
  logic [N_REQ-1:0]   win_onehot;
  logic [W-1:0]       xor_out;

  // The single shared compute unit, fed from the captured operands.
  xor_vec_using_mux #(.W(W)) u_xor (
    .a (a_q),
    .b (b_q),
    .o (xor_out)
  );

  always_comb begin
    valid_ext              = '0;
    valid_ext[N_REQ-1:0]   = req_valid;
    pick                   = rr_pick(valid_ext, MAX_ID_W'(rr_ptr_q), N_REQ);
    win_idx                = ID_W'(pick.idx);
    win_onehot             = '0;
    for (int i = 0; i < N_REQ; i++) begin
      win_onehot[i] = (win_idx == ID_W'(i));
    end
  end

  // Grant is only offered in IDLE; gating with rst_n keeps it low while the
  // reset is held even though valids may already be asserted.
  assign req_ready = (rst_n && state_q == IDLE && pick.found) ? win_onehot : '0;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    op_count_d  = op_count_q;
    case (state_q)
      IDLE: begin
        if (pick.found) begin
          a_d      = req_a[win_idx*W +: W];
          b_d      = req_b[win_idx*W +: W];
          id_d     = win_idx;
          // Explicit wrap so non-power-of-2 N_REQ never yields ptr >= N_REQ.
          rr_ptr_d = (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + ID_W'(1);
          state_d  = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d  = xor_out;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + CNT_W'(1);
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      op_count_q  <= op_count_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_id     = rsp_id_q;
  assign op_count   = op_count_q;
  assign busy       = (state_q != IDLE);
  assign dbg_state  = state_q;
  assign dbg_rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_xor_mux_share_arbiter.sv
module tb_xor_mux_share_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance with default parameters (N_REQ=4, W=8, CNT_W=16)
  logic [3:0]  v4;
  logic [31:0] a4, b4;
  logic        rr4;
  logic [3:0]  rdy4;
  logic        rv4;
  logic [7:0]  rd4;
  logic [1:0]  rid4;
  logic        busy4;
  logic [15:0] cnt4;
  logic [1:0]  st4;
  logic [1:0]  ptr4;

  // Instance with N_REQ=3 (non power of 2) and a 4-bit counter
  logic [2:0]  v3;
  logic [23:0] a3, b3;
  logic        rr3;
  logic [2:0]  rdy3;
  logic        rv3;
  logic [7:0]  rd3;
  logic [1:0]  rid3;
  logic        busy3;
  logic [3:0]  cnt3;
  logic [1:0]  st3;
  logic [1:0]  ptr3;

  // Stand-alone shared unit for an exhaustive operand sweep
  logic [7:0] sa, sb, so;

  xor_mux_share_arbiter dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(v4), .req_ready(rdy4),
    .req_a(a4), .req_b(b4), .rsp_valid(rv4), .rsp_ready(rr4),
    .rsp_data(rd4), .rsp_id(rid4), .busy(busy4), .op_count(cnt4),
    .dbg_state(st4), .dbg_rr_ptr(ptr4)
  );

  xor_mux_share_arbiter #(.N_REQ(3), .W(8), .CNT_W(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_ready(rdy3),
    .req_a(a3), .req_b(b3), .rsp_valid(rv3), .rsp_ready(rr3),
    .rsp_data(rd3), .rsp_id(rid3), .busy(busy3), .op_count(cnt3),
    .dbg_state(st3), .dbg_rr_ptr(ptr3)
  );

  xor_vec_using_mux #(.W(8)) uxor (.a(sa), .b(sb), .o(so));

  // Reference model state: round-robin start and completed-op counts
  int m_ptr4 = 0, m_cnt4 = 0, m_ptr3 = 0, m_cnt3 = 0;

  // Winner by the fairness rule: first valid requester at or after ptr, wrapping.
  function automatic int model_pick(input int n, input int ptr, input logic [15:0] valid);
    for (int k = 0; k < n; k++) begin
      if (valid[(ptr + k) % n]) return (ptr + k) % n;
    end
    return -1;
  endfunction

  // One full transaction on dut4, starting in IDLE at posedge+1.
  task automatic op4(input logic [3:0] valid, input logic [31:0] a, input logic [31:0] b,
                     input int stall);
    int win;
    logic [7:0] exp_d;
    logic [3:0] exp_rdy;
    win = model_pick(4, m_ptr4, 16'(valid));
    v4 = valid; a4 = a; b4 = b; rr4 = 1'b0;
    #1;
    if (win < 0) begin
      checks++;
      if (rdy4 !== 4'b0) begin errors++; $display("FAIL idle_ready4: got %b want 0000", rdy4); end
      @(posedge clk); #1;
      checks++;
      if (busy4 !== 1'b0 || ptr4 !== 2'(m_ptr4)) begin
        errors++; $display("FAIL idle_stay4: busy %b ptr %0d want busy 0 ptr %0d", busy4, ptr4, m_ptr4);
      end
      v4 = '0;
      return;
    end
    exp_rdy = 4'(1 << win);
    exp_d   = a[win*8 +: 8] ^ b[win*8 +: 8];
    checks++;
    if (rdy4 !== exp_rdy) begin errors++; $display("FAIL grant4: got %b want %b", rdy4, exp_rdy); end
    @(posedge clk); #1;
    m_ptr4 = (win + 1) % 4;
    v4 = 4'hF;
    #1;
    checks++;
    if (rdy4 !== 4'b0 || busy4 !== 1'b1 || rv4 !== 1'b0 || ptr4 !== 2'(m_ptr4)) begin
      errors++;
      $display("FAIL exec4: rdy %b busy %b rv %b ptr %0d want 0000 1 0 %0d", rdy4, busy4, rv4, ptr4, m_ptr4);
    end
    @(posedge clk); #1;
    checks++;
    if (rv4 !== 1'b1 || rd4 !== exp_d || rid4 !== 2'(win)) begin
      errors++; $display("FAIL resp4: rv %b data %h id %0d want 1 %h %0d", rv4, rd4, rid4, exp_d, win);
    end
    repeat (stall) begin
      @(posedge clk); #1;
      checks++;
      if (rv4 !== 1'b1 || rd4 !== exp_d || rid4 !== 2'(win) || rdy4 !== 4'b0) begin
        errors++;
        $display("FAIL hold4: rv %b data %h id %0d rdy %b want 1 %h %0d 0000", rv4, rd4, rid4, rdy4, exp_d, win);
      end
    end
    rr4 = 1'b1;
    @(posedge clk); #1;
    rr4 = 1'b0; v4 = '0;
    m_cnt4++;
    checks++;
    if (rv4 !== 1'b0 || busy4 !== 1'b0 || cnt4 !== 16'(m_cnt4)) begin
      errors++; $display("FAIL done4: rv %b busy %b count %0d want 0 0 %0d", rv4, busy4, cnt4, 16'(m_cnt4));
    end
  endtask

  // One full transaction on dut3 (N_REQ=3), starting in IDLE at posedge+1.
  task automatic op3(input logic [2:0] valid, input logic [23:0] a, input logic [23:0] b,
                     input int stall);
    int win;
    logic [7:0] exp_d;
    win = model_pick(3, m_ptr3, 16'(valid));
    v3 = valid; a3 = a; b3 = b; rr3 = 1'b0;
    #1;
    exp_d = a[win*8 +: 8] ^ b[win*8 +: 8];
    checks++;
    if (rdy3 !== 3'(1 << win)) begin errors++; $display("FAIL grant3: got %b want %b", rdy3, 3'(1 << win)); end
    @(posedge clk); #1;
    m_ptr3 = (win + 1) % 3;
    v3 = 3'b111;
    #1;
    checks++;
    if (rdy3 !== 3'b0 || busy3 !== 1'b1 || ptr3 !== 2'(m_ptr3) || ptr3 > 2'd2) begin
      errors++; $display("FAIL exec3: rdy %b busy %b ptr %0d want 000 1 %0d", rdy3, busy3, ptr3, m_ptr3);
    end
    @(posedge clk); #1;
    checks++;
    if (rv3 !== 1'b1 || rd3 !== exp_d || rid3 !== 2'(win)) begin
      errors++; $display("FAIL resp3: rv %b data %h id %0d want 1 %h %0d", rv3, rd3, rid3, exp_d, win);
    end
    repeat (stall) @(posedge clk);
    #1;
    rr3 = 1'b1;
    @(posedge clk); #1;
    rr3 = 1'b0; v3 = '0;
    m_cnt3++;
    checks++;
    if (rv3 !== 1'b0 || busy3 !== 1'b0 || cnt3 !== 4'(m_cnt3)) begin
      errors++; $display("FAIL done3: rv %b busy %b count %0d want 0 0 %0d", rv3, busy3, cnt3, 4'(m_cnt3));
    end
  endtask

  task automatic test_reset();
    v4 = 4'hF; a4 = $urandom; b4 = $urandom; rr4 = 1'b1;
    v3 = 3'b111; a3 = 24'($urandom); b3 = 24'($urandom); rr3 = 1'b1;
    #1;
    checks++;
    if (rdy4 !== 4'b0 || rv4 !== 1'b0 || rd4 !== 8'h00 || rid4 !== 2'd0 || busy4 !== 1'b0 ||
        cnt4 !== 16'd0 || ptr4 !== 2'd0) begin
      errors++;
      $display("FAIL reset4: rdy %b rv %b data %h id %0d busy %b cnt %0d ptr %0d want all zero",
               rdy4, rv4, rd4, rid4, busy4, cnt4, ptr4);
    end
    checks++;
    if (rdy3 !== 3'b0 || rv3 !== 1'b0 || busy3 !== 1'b0 || cnt3 !== 4'd0 || ptr3 !== 2'd0) begin
      errors++; $display("FAIL reset3: rdy %b rv %b busy %b cnt %0d ptr %0d want all zero",
                         rdy3, rv3, busy3, cnt3, ptr3);
    end
    repeat (2) @(posedge clk);
    #1;
    v4 = '0; v3 = '0; rr4 = 1'b0; rr3 = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    op4(4'b0100, 32'h00A5_0000, 32'h000F_0000, 0);
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_q[$];
    logic [1:0] id_q[$];
    logic [7:0] ed;
    logic [1:0] ei;
    int last, grants, w;
    a4 = $urandom; b4 = $urandom; v4 = 4'hF; rr4 = 1'b1;
    last = -1; grants = 0;
    #1;
    for (int c = 0; c < 18; c++) begin
      if (rdy4 !== 4'b0) begin
        w = model_pick(4, m_ptr4, 16'hF);
        checks++;
        if (rdy4 !== 4'(1 << w)) begin errors++; $display("FAIL rr_grant: got %b want %b", rdy4, 4'(1 << w)); end
        if (last >= 0) begin
          checks++;
          if (c - last != 3) begin errors++; $display("FAIL rr_spacing: got %0d want 3", c - last); end
        end
        last = c; grants++;
        m_ptr4 = (w + 1) % 4;
        exp_q.push_back(a4[w*8 +: 8] ^ b4[w*8 +: 8]);
        id_q.push_back(2'(w));
      end
      if (rv4 === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rr_unexpected: got response id %0d want none", rid4);
        end else begin
          ed = exp_q.pop_front();
          ei = id_q.pop_front();
          if (rd4 !== ed || rid4 !== ei) begin
            errors++; $display("FAIL rr_resp: data %h id %0d want %h %0d", rd4, rid4, ed, ei);
          end
        end
      end
      @(posedge clk); #1;
    end
    v4 = '0; rr4 = 1'b0;
    m_cnt4 += 6;
    checks++;
    if (grants != 6 || exp_q.size() != 0 || busy4 !== 1'b0 || cnt4 !== 16'(m_cnt4) || ptr4 !== 2'(m_ptr4)) begin
      errors++;
      $display("FAIL rr_total: grants %0d left %0d busy %b cnt %0d ptr %0d want 6 0 0 %0d %0d",
               grants, exp_q.size(), busy4, cnt4, ptr4, 16'(m_cnt4), m_ptr4);
    end
  endtask

  task automatic test_backpressure();
    op4(4'(1 << $urandom_range(0, 3)), $urandom, $urandom, 10);
  endtask

  task automatic test_random4();
    for (int i = 0; i < 20; i++) begin
      op4(4'($urandom_range(0, 15)), $urandom, $urandom, $urandom_range(0, 3));
    end
  endtask

  task automatic test_reset_mid_op();
    v4 = 4'b0010; a4 = $urandom; b4 = $urandom; rr4 = 1'b0;
    @(posedge clk); #1;
    v4 = '0;
    @(posedge clk); #1;
    checks++;
    if (rv4 !== 1'b1) begin errors++; $display("FAIL pre_reset_resp: rv %b want 1", rv4); end
    v4 = 4'hF; rr4 = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (rv4 !== 1'b0 || busy4 !== 1'b0 || cnt4 !== 16'd0 || ptr4 !== 2'd0 || rdy4 !== 4'b0) begin
      errors++;
      $display("FAIL async_reset: rv %b busy %b cnt %0d ptr %0d rdy %b want 0 0 0 0 0000",
               rv4, busy4, cnt4, ptr4, rdy4);
    end
    m_ptr4 = 0; m_cnt4 = 0; m_ptr3 = 0; m_cnt3 = 0;
    @(posedge clk); #1;
    v4 = '0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rv4 !== 1'b0 || busy4 !== 1'b0) begin
        errors++; $display("FAIL stale_resp: rv %b busy %b want 0 0", rv4, busy4);
      end
    end
    rr4 = 1'b0;
  endtask

  task automatic test_wrap3();
    op3(3'b010, 24'($urandom), 24'($urandom), 0);  // leaves the pointer at 2
    op3(3'b101, 24'($urandom), 24'($urandom), 1);  // 2 wins over 0
    op3(3'b001, 24'($urandom), 24'($urandom), 0);  // pointer wrapped to 0
  endtask

  task automatic test_counter_wrap();
    for (int i = 0; i < 14; i++) begin
      op3(3'($urandom_range(1, 7)), 24'($urandom), 24'($urandom), $urandom_range(0, 2));
    end
    // 17 completed ops since reset on a 4-bit counter
    checks++;
    if (cnt3 !== 4'd1) begin errors++; $display("FAIL count_wrap: got %0d want 1", cnt3); end
  endtask

  task automatic test_xor_sweep();
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 256; j++) begin
        sa = 8'(i); sb = 8'(j);
        #1;
        checks++;
        if (so !== 8'(i ^ j)) begin
          errors++; $display("FAIL xor_sweep: a %h b %h got %h want %h", sa, sb, so, 8'(i ^ j));
        end
      end
    end
  endtask

  initial begin
    sa = '0; sb = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_random4();
    test_reset_mid_op();
    test_wrap3();
    test_counter_wrap();
    test_xor_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
